ball_motion_ctrl: RTL and testbench
===================================

Name: ball_motion_ctrl

Overview:
Upstream motion engine for the ball renderer. Once per frame it advances the ball centre position on a strobe from the sync generator's frame-start point (x==0, y==0). It reflects the ball off the active-area edges with exact clamping, so it never overshoots. It drives ball_x/ball_y, direction and a hit-flash indication to the pixel renderer, which consumes them combinationally.

Parameters:
H_ACTIVE, 640, visible width in pixels
V_ACTIVE, 480, visible height in lines
BALL_SIZE, 20, ball radius; centre confined to [BALL_SIZE, ACTIVE-BALL_SIZE]
X_INIT, 320, reset/launch centre x
Y_INIT, 240, reset/launch centre y
SPEED_BASE, 2, pixels per frame at speed_sel=0
LAUNCH_FRAMES, 60, frames held at init position after reset
FLASH_FRAMES, 8, frames hit_flash stays high after a bounce

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
frame_tick  input  1  one-cycle pulse per frame (sync generator at x==0,y==0)
pause  input  1  level; freezes motion while high
speed_sel  input  2  step = SPEED_BASE*(speed_sel+1): 2,4,6,8 at defaults
ball_x  output  10  ball centre x
ball_y  output  10  ball centre y
dir_x  output  1  1=right, 0=left
dir_y  output  1  1=down, 0=up
bounce  output  1  one-cycle pulse on any edge reflection
hit_flash  output  1  high for FLASH_FRAMES frames after last bounce
state_o  output  2  current FSM state (debug)

Behaviour:
- Reset (async assert, sync release): ball_x=X_INIT, ball_y=Y_INIT, dir_x=1, dir_y=1, bounce=0, hit_flash=0, flash_cnt=0, launch_cnt=0, state=LAUNCH.
- All outputs are registered. Updates take effect the cycle after frame_tick, so the renderer sees new values from pixel (1,0). No other cycle changes position.
- FSM states: LAUNCH=0, RUN=1, PAUSED=2. Encoding 3 is unreachable and recovers to LAUNCH.
- LAUNCH: position held at init. launch_cnt increments on each frame_tick. On the tick where launch_cnt==LAUNCH_FRAMES-1, go to RUN. Position does not move on that tick; the first move is on the next tick.
- RUN: on frame_tick with pause=1, go to PAUSED with no move. On frame_tick with pause=0, move both axes.
- PAUSED: on frame_tick with pause=0, go to RUN with no move that tick. pause is sampled only on frame_tick.
- Step: step = SPEED_BASE*(speed_sel+1), with speed_sel sampled on frame_tick.
- Axis update, per axis, with MIN=BALL_SIZE and MAX=ACTIVE-BALL_SIZE. Compute in 11-bit signed to avoid wrap.
  - dir=1: nxt=pos+step. If nxt>=MAX: pos=MAX, dir=0, hit. Else pos=nxt.
  - dir=0: nxt=pos-step. If nxt<=MIN: pos=MIN, dir=1, hit. Else pos=nxt.
  - Landing exactly on MAX or MIN counts as a hit.
- Corner case: both axes hit on the same tick. Both reflect, and bounce is a single one-cycle pulse.
- bounce: high for exactly the cycle after a tick with any hit, otherwise 0.
- Flash counter:
  - On a hit tick: flash_cnt=FLASH_FRAMES.
  - Else on a frame_tick with flash_cnt>0: flash_cnt decrements.
  - A new hit while flashing reloads the counter.
  - hit_flash = (flash_cnt != 0), registered.
- speed_sel change mid-flight: takes effect on the next tick. Clamping guarantees the position stays in range at any step.
- frame_tick while rst_n is low is ignored. Reset mid-flight returns immediately to the reset values and restarts LAUNCH.
- Range: ball_x always within [20,620] and ball_y within [20,460] at defaults.

Decomposition:
- Shared package vga_pkg:
  - H_ACTIVE/V_ACTIVE constants
  - FSM state enum (ST_LAUNCH, ST_RUN, ST_PAUSED)
  - a step-width typedef (11-bit signed)
- One natural sub-module, ball_axis_step, instantiated twice (x, y).
  - Inputs: pos, dir, step, min, max.
  - Outputs: next pos, next dir, hit.
  - Purely combinational; the parent owns the registers and the FSM.

Test Plan:
- Release reset, apply 59 frame_ticks -> state=LAUNCH, ball=(320,240). Tick 60 -> state=RUN, ball=(320,240). Tick 61 -> ball=(322,242), dir=(1,1).
- RUN, speed_sel=3, start x=616 dir_x=1 -> one tick gives ball_x=620, dir_x=0, a one-cycle bounce pulse and hit_flash=1. Eight further ticks with no hit -> hit_flash=0.
- Force approach to corner (618,458), dir=(1,1), step 2 -> single tick gives (620,460), dir=(0,0) and exactly one bounce pulse.
- pause=1 at tick N -> state=PAUSED and position frozen over 10 ticks. pause=0 -> state=RUN with no move that tick; movement resumes on the following tick.
- Left edge: x=23, dir_x=0, speed_sel=1 (step 4) -> ball_x=20, dir_x=1, bounce. No value below 20 ever appears.
- Assert rst_n=0 asynchronously between ticks mid-RUN -> outputs return to reset values within the same cycle. After release, LAUNCH restarts and 60 ticks are required before motion.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants and types.
// Ball motion FSM states and the signed axis arithmetic type.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    ST_LAUNCH = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  typedef logic signed [10:0] step_t;

endpackage

// File: rtl/ball_axis_step.sv
// One-axis reflect/clamp step for the ball centre (combinational).
// pos/dir/step/lo/hi in; nxt_pos/nxt_dir/hit out.
module ball_axis_step
  import vga_pkg::*;
(
  input  logic [9:0] pos,
  input  logic       dir,
  input  step_t      step,
  input  step_t      lo,
  input  step_t      hi,
  output logic [9:0] nxt_pos,
  output logic       nxt_dir,
  output logic       hit
);

  step_t cur;
  step_t fwd;
  step_t bwd;

  assign cur = $signed({1'b0, pos});
  assign fwd = cur + step;
  assign bwd = cur - step;

  always_comb begin
    nxt_pos = pos;
    nxt_dir = dir;
    hit     = 1'b0;
    if (dir) begin
      if (fwd >= hi) begin
        nxt_pos = hi[9:0];
        nxt_dir = 1'b0;
        hit     = 1'b1;
      end else begin
        nxt_pos = fwd[9:0];
      end
    end else begin
      if (bwd <= lo) begin
        nxt_pos = lo[9:0];
        nxt_dir = 1'b1;
        hit     = 1'b1;
      end else begin
        nxt_pos = bwd[9:0];
      end
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball motion engine: launch hold, run/pause, edge bounce.
// In: clk rst_n frame_tick pause speed_sel. Out: ball_x/y dir_x/y bounce hit_flash state_o.
module ball_motion_ctrl #(
  parameter int H_ACTIVE      = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE      = vga_pkg::V_ACTIVE,
  parameter int BALL_SIZE     = 20,
  parameter int X_INIT        = 320,
  parameter int Y_INIT        = 240,
  parameter int SPEED_BASE    = 2,
  parameter int LAUNCH_FRAMES = 60,
  parameter int FLASH_FRAMES  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       pause,
  input  logic [1:0] speed_sel,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       bounce,
  output logic       hit_flash,
  output logic [1:0] state_o
);

  import vga_pkg::*;

  localparam int LW = $clog2(LAUNCH_FRAMES + 1);
  localparam int FW = $clog2(FLASH_FRAMES + 1);

  localparam step_t X_MIN = step_t'(BALL_SIZE);
  localparam step_t X_MAX = step_t'(H_ACTIVE - BALL_SIZE);
  localparam step_t Y_MIN = step_t'(BALL_SIZE);
  localparam step_t Y_MAX = step_t'(V_ACTIVE - BALL_SIZE);

  state_t        state;
  state_t        state_nxt;
  logic [LW-1:0] launch_cnt;
  logic [LW-1:0] launch_nxt;
  logic [FW-1:0] flash_cnt;
  logic [FW-1:0] flash_nxt;
  logic          move;
  logic          hit_any;
  step_t         step;

  logic [9:0] nx;
  logic [9:0] ny;
  logic       ndx;
  logic       ndy;
  logic       hx;
  logic       hy;

  assign step    = step_t'(SPEED_BASE * (int'(speed_sel) + 1));
  assign state_o = state;
  assign hit_any = move & (hx | hy);

  ball_axis_step u_x (
    .pos     (ball_x),
    .dir     (dir_x),
    .step    (step),
    .lo      (X_MIN),
    .hi      (X_MAX),
    .nxt_pos (nx),
    .nxt_dir (ndx),
    .hit     (hx)
  );

  ball_axis_step u_y (
    .pos     (ball_y),
    .dir     (dir_y),
    .step    (step),
    .lo      (Y_MIN),
    .hi      (Y_MAX),
    .nxt_pos (ny),
    .nxt_dir (ndy),
    .hit     (hy)
  );

  always_comb begin
    state_nxt  = state;
    launch_nxt = launch_cnt;
    move       = 1'b0;
    case (state)
      ST_LAUNCH: begin
        if (frame_tick) begin
          launch_nxt = launch_cnt + LW'(1);
          if (launch_cnt == LW'(LAUNCH_FRAMES - 1))
            state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (frame_tick) begin
          if (pause) state_nxt = ST_PAUSED;
          else       move      = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (frame_tick && !pause)
          state_nxt = ST_RUN;
      end
      default: begin
        state_nxt  = ST_LAUNCH;
        launch_nxt = '0;
      end
    endcase
  end

  // Hit reloads; otherwise each frame counts the flash down.
  always_comb begin
    flash_nxt = flash_cnt;
    if (hit_any)
      flash_nxt = FW'(FLASH_FRAMES);
    else if (frame_tick && flash_cnt != '0)
      flash_nxt = flash_cnt - FW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LAUNCH;
      launch_cnt <= '0;
      flash_cnt  <= '0;
      hit_flash  <= 1'b0;
      bounce     <= 1'b0;
      ball_x     <= 10'(X_INIT);
      ball_y     <= 10'(Y_INIT);
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
    end else begin
      state      <= state_nxt;
      launch_cnt <= launch_nxt;
      flash_cnt  <= flash_nxt;
      hit_flash  <= (flash_nxt != '0);
      bounce     <= hit_any;
      if (move) begin
        ball_x <= nx;
        ball_y <= ny;
        dir_x  <= ndx;
        dir_y  <= ndy;
      end
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl.
// Scenario tasks with inline checks against hand values and a frame model.
module tb_ball_motion_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       pause;
  logic [1:0] speed_sel;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       dir_x;
  logic       dir_y;
  logic       bounce;
  logic       hit_flash;
  logic [1:0] state_o;

  int total;
  int bad;

  int mx, my, mst, mlc, mfl;
  bit mdx, mdy, mhit;

  logic [26:0] obs;
  logic [26:0] expv;
  logic [26:0] rst_v;

  assign obs = {ball_x, ball_y, dir_x, dir_y,
                bounce, hit_flash, state_o};

  ball_motion_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .pause      (pause),
    .speed_sel  (speed_sel),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .dir_x      (dir_x),
    .dir_y      (dir_y),
    .bounce     (bounce),
    .hit_flash  (hit_flash),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    mx = 320; my = 240; mdx = 1; mdy = 1;
    mst = 0; mlc = 0; mfl = 0; mhit = 0;
  endtask

  task automatic axis(input int p, input bit d, input int s,
                      input int lo, input int hi,
                      output int np, output bit nd, output bit h);
    np = p; nd = d; h = 0;
    if (d) begin
      if (p + s >= hi) begin np = hi; nd = 0; h = 1; end
      else np = p + s;
    end else begin
      if (p - s <= lo) begin np = lo; nd = 1; h = 1; end
      else np = p - s;
    end
  endtask

  task automatic model_tick(input int sp, input bit pz);
    int s;
    bit hx, hy;
    s = 2 * (sp + 1);
    mhit = 0;
    case (mst)
      0: begin
        if (mlc == 59) mst = 1;
        mlc++;
      end
      1: begin
        if (pz) mst = 2;
        else begin
          axis(mx, mdx, s, 20, 620, mx, mdx, hx);
          axis(my, mdy, s, 20, 460, my, mdy, hy);
          mhit = hx | hy;
        end
      end
      default: if (!pz) mst = 1;
    endcase
    if (mhit) mfl = 8;
    else if (mfl > 0) mfl--;
    expv = {10'(mx), 10'(my), mdx, mdy,
            mhit, (mfl != 0), 2'(mst)};
  endtask

  task automatic tick(input logic [1:0] sp, input logic pz);
    @(negedge clk);
    speed_sel  = sp;
    pause      = pz;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    model_tick(int'(sp), pz);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    frame_tick = 1'b0;
    pause = 1'b0;
    speed_sel = 2'd0;
    repeat (2) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    total++;
    if (obs !== rst_v) begin
      bad++;
      $display("FAIL reset got=%h exp=%h", obs, rst_v);
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    total++;
    if (obs !== rst_v) begin
      bad++;
      $display("FAIL reset_release got=%h exp=%h", obs, rst_v);
    end
  endtask

  task automatic test_launch(input string tag);
    repeat (59) tick(2'd0, 1'b0);
    total++;
    if ({state_o, ball_x, ball_y} !== {2'd0, 10'd320, 10'd240}) begin
      bad++;
      $display("FAIL %s_hold st=%0d x=%0d y=%0d exp 0/320/240",
               tag, state_o, ball_x, ball_y);
    end
    tick(2'd0, 1'b0);
    total++;
    if ({state_o, ball_x, ball_y} !== {2'd1, 10'd320, 10'd240}) begin
      bad++;
      $display("FAIL %s_run st=%0d x=%0d y=%0d exp 1/320/240",
               tag, state_o, ball_x, ball_y);
    end
    tick(2'd0, 1'b0);
    total++;
    if ({ball_x, ball_y, dir_x, dir_y} !==
        {10'd322, 10'd242, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL %s_move x=%0d y=%0d d=%b%b exp 322/242/11",
               tag, ball_x, ball_y, dir_x, dir_y);
    end
  endtask

  task automatic test_right_edge();
    tick(2'd2, 1'b0);
    for (int i = 0; i < 36; i++) begin
      tick(2'd3, 1'b0);
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL track_r got=%h exp=%h", obs, expv);
      end
    end
    total++;
    if ({ball_x, ball_y, dir_x} !== {10'd616, 10'd388, 1'b1}) begin
      bad++;
      $display("FAIL pre_edge x=%0d y=%0d dx=%b exp 616/388/1",
               ball_x, ball_y, dir_x);
    end
    tick(2'd3, 1'b0);
    total++;
    if ({ball_x, dir_x, bounce, hit_flash} !==
        {10'd620, 1'b0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL right_hit x=%0d dx=%b b=%b f=%b exp 620/0/1/1",
               ball_x, dir_x, bounce, hit_flash);
    end
    @(negedge clk);
    total++;
    if (bounce !== 1'b0) begin
      bad++;
      $display("FAIL right_pulse bounce=%b exp 0", bounce);
    end
    repeat (7) tick(2'd3, 1'b0);
    total++;
    if (hit_flash !== 1'b1) begin
      bad++;
      $display("FAIL flash_hold f=%b exp 1", hit_flash);
    end
    tick(2'd3, 1'b0);
    total++;
    if ({hit_flash, ball_x, ball_y} !== {1'b0, 10'd556, 10'd316}) begin
      bad++;
      $display("FAIL flash_end f=%b x=%0d y=%0d exp 0/556/316",
               hit_flash, ball_x, ball_y);
    end
  endtask

  task automatic test_corner();
    bit found;
    int pulses;
    found = 0;
    for (int i = 0; i < 6000 && !found; i++) begin
      tick(2'd0, 1'b0);
      total++;
      if (obs !== expv || ball_x < 20 || ball_x > 620 ||
          ball_y < 20 || ball_y > 460) begin
        bad++;
        $display("FAIL track_c got=%h exp=%h", obs, expv);
      end
      if (mx == 618 && my == 458 && mdx && mdy) found = 1;
    end
    total++;
    if (!found || {ball_x, ball_y} !== {10'd618, 10'd458}) begin
      bad++;
      $display("FAIL corner_reach x=%0d y=%0d exp 618/458",
               ball_x, ball_y);
    end
    tick(2'd0, 1'b0);
    pulses = int'(bounce);
    total++;
    if ({ball_x, ball_y, dir_x, dir_y} !==
        {10'd620, 10'd460, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL corner x=%0d y=%0d d=%b%b exp 620/460/00",
               ball_x, ball_y, dir_x, dir_y);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pulses += int'(bounce);
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL corner_pulse count=%0d exp 1", pulses);
    end
  endtask

  task automatic test_pause();
    tick(2'd0, 1'b1);
    total++;
    if ({state_o, ball_x, ball_y} !== {2'd2, 10'd620, 10'd460}) begin
      bad++;
      $display("FAIL pause_enter st=%0d x=%0d y=%0d exp 2/620/460",
               state_o, ball_x, ball_y);
    end
    for (int i = 0; i < 10; i++) begin
      tick(2'd3, 1'b1);
      total++;
      if ({state_o, ball_x, ball_y} !==
          {2'd2, 10'd620, 10'd460}) begin
        bad++;
        $display("FAIL pause_hold st=%0d x=%0d y=%0d exp 2/620/460",
                 state_o, ball_x, ball_y);
      end
    end
    tick(2'd0, 1'b0);
    total++;
    if ({state_o, ball_x, ball_y} !== {2'd1, 10'd620, 10'd460}) begin
      bad++;
      $display("FAIL resume st=%0d x=%0d y=%0d exp 1/620/460",
               state_o, ball_x, ball_y);
    end
    tick(2'd0, 1'b0);
    total++;
    if ({ball_x, ball_y, hit_flash} !==
        {10'd618, 10'd458, 1'b0}) begin
      bad++;
      $display("FAIL resume_move x=%0d y=%0d f=%b exp 618/458/0",
               ball_x, ball_y, hit_flash);
    end
  endtask

  task automatic test_left_edge();
    for (int i = 0; i < 298; i++) begin
      tick(2'd0, 1'b0);
      total++;
      if (obs !== expv || ball_x < 20 || ball_y < 20) begin
        bad++;
        $display("FAIL track_l got=%h exp=%h", obs, expv);
      end
    end
    total++;
    if ({ball_x, ball_y, dir_x} !== {10'd22, 10'd178, 1'b0}) begin
      bad++;
      $display("FAIL pre_left x=%0d y=%0d dx=%b exp 22/178/0",
               ball_x, ball_y, dir_x);
    end
    tick(2'd1, 1'b0);
    total++;
    if ({ball_x, ball_y, dir_x, bounce} !==
        {10'd20, 10'd182, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL left_hit x=%0d y=%0d dx=%b b=%b exp 20/182/1/1",
               ball_x, ball_y, dir_x, bounce);
    end
  endtask

  task automatic test_reset_mid();
    repeat (3) tick(2'd2, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== rst_v) begin
      bad++;
      $display("FAIL mid_reset got=%h exp=%h", obs, rst_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    test_launch("relaunch");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_v = {10'd320, 10'd240, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
    model_reset();
    test_reset();
    test_launch("launch");
    test_right_edge();
    test_corner();
    test_pause();
    test_left_edge();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
